// File: rtl/fredkin_pkg.sv
// rtl/fredkin_pkg.sv - shared constants for the Fredkin counter slice
package fredkin_pkg;

   localparam int WIDTH_MIN = 2;
   localparam int WIDTH_MAX = 16;

   // Tie-off values for gate inputs held at a fixed level
   localparam logic CONST0 = 1'b0;
   localparam logic CONST1 = 1'b1;

endpackage

// File: rtl/fredkin.sv
// rtl/fredkin.sv - Fredkin controlled-swap primitive: p=a, q=a'b+ac, r=a'c+ab
module fredkin (
   input  logic a,
   input  logic b,
   input  logic c,
   output logic p,
   output logic q,
   output logic r
);

   assign p = a;
   assign q = (~a & b) | (a & c);
   assign r = (~a & c) | (a & b);

endmodule

// File: rtl/fredkin_dff.sv
// rtl/fredkin_dff.sv - single-bit rising-edge register, sync active-high reset, qb via Fredkin NOT
module fredkin_dff
   import fredkin_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q,
   output logic qb
);

   logic q_r;
   logic not_unused_p;
   logic not_unused_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         q_r <= 1'b0;
      end else begin
         q_r <= d;
      end
   end

   assign q = q_r;

   fredkin u_not (
      .a (q_r),
      .b (CONST0),
      .c (CONST1),
      .p (not_unused_p),
      .q (not_unused_q),
      .r (qb)
   );

endmodule

// File: rtl/fredkin_updown_counter.sv
// rtl/fredkin_updown_counter.sv - up/down counter with parallel load, next-state logic built from Fredkin gates
module fredkin_updown_counter
   import fredkin_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             load,
   input  logic             up,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] qb,
   output logic             tc
);

   if ((WIDTH < WIDTH_MIN) || (WIDTH > WIDTH_MAX)) begin : g_width_check
      $error("fredkin_updown_counter: WIDTH out of range");
   end

   // The toggle chain starts at en, so the final AND output is exactly the terminal count.
   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      logic t_in;
      logic t_out;
      logic chain_in;
      logic cnt_next;
      logic d_next;
      logic dir_unused_p, dir_unused_r;
      logic and_unused_p, and_unused_q;
      logic xor_unused_p, xor_unused_r;
      logic ld_unused_p,  ld_unused_r;

      if (i == 0) begin : g_first
         assign t_in = en;
      end else begin : g_rest
         assign t_in = g_bit[i-1].t_out;
      end

      // Counting up ripples through ones of q; counting down ripples through ones of qb.
      fredkin u_dir (
         .a (up),
         .b (qb[i]),
         .c (q[i]),
         .p (dir_unused_p),
         .q (chain_in),
         .r (dir_unused_r)
      );

      fredkin u_and (
         .a (t_in),
         .b (chain_in),
         .c (CONST0),
         .p (and_unused_p),
         .q (and_unused_q),
         .r (t_out)
      );

      // XOR(q, t): select the stored bit or its complement by the toggle.
      fredkin u_xor (
         .a (t_in),
         .b (q[i]),
         .c (qb[i]),
         .p (xor_unused_p),
         .q (cnt_next),
         .r (xor_unused_r)
      );

      fredkin u_ld (
         .a (load),
         .b (cnt_next),
         .c (d[i]),
         .p (ld_unused_p),
         .q (d_next),
         .r (ld_unused_r)
      );

      fredkin_dff u_dff (
         .clk (clk),
         .rst (rst),
         .d   (d_next),
         .q   (q[i]),
         .qb  (qb[i])
      );
   end

   assign tc = g_bit[WIDTH-1].t_out;

endmodule

// File: tb/tb_fredkin_updown_counter.sv
// tb/tb_fredkin_updown_counter.sv - scoreboard bench for fredkin_updown_counter
module tb_fredkin_updown_counter;

   localparam int W = 4;
   localparam int MOD = 1 << W;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         en = 1'b0;
   logic         load = 1'b0;
   logic         up = 1'b0;
   logic [W-1:0] d = '0;
   logic [W-1:0] q;
   logic [W-1:0] qb;
   logic         tc;

   typedef struct packed {
      logic [W-1:0] q;
      logic         tc;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   model_q = 0;
   bit   model_known = 1'b0;

   fredkin_updown_counter #(.WIDTH(W)) dut (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .load (load),
      .up   (up),
      .d    (d),
      .q    (q),
      .qb   (qb),
      .tc   (tc)
   );

   always #5 clk = ~clk;

   // Drive one cycle of inputs, record what the outputs must show during it,
   // then advance the reference count for the coming edge.
   task automatic step(input logic r, input logic l, input logic e, input logic u,
                       input logic [W-1:0] dv);
      exp_t e_v;
      @(posedge clk);
      #2;
      rst  = r;
      load = l;
      en   = e;
      up   = u;
      d    = dv;
      if (model_known) begin
         e_v.q  = W'(model_q);
         e_v.tc = e && (u ? (model_q == MOD - 1) : (model_q == 0));
         sb.push_back(e_v);
      end
      if (r) begin
         model_q     = 0;
         model_known = 1'b1;
      end else if (l) begin
         model_q     = int'(dv);
         model_known = 1'b1;
      end else if (e) begin
         model_q = u ? (model_q + 1) % MOD : (model_q + MOD - 1) % MOD;
      end
   endtask

   initial begin : monitor
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            exp_t e_v;
            e_v = sb.pop_front();
            checks++;
            if (q !== e_v.q) begin
               errors++;
               $display("FAIL q: got %h expected %h at %0t", q, e_v.q, $time);
            end
            checks++;
            if (qb !== ~e_v.q) begin
               errors++;
               $display("FAIL qb: got %h expected %h at %0t", qb, ~e_v.q, $time);
            end
            checks++;
            if (tc !== e_v.tc) begin
               errors++;
               $display("FAIL tc: got %b expected %b at %0t", tc, e_v.tc, $time);
            end
         end
      end
   end

   initial begin : stimulus
      // reset dominates load/en
      step(1, 1, 1, 0, 4'hA);
      step(1, 1, 1, 0, 4'hA);
      // up wrap
      step(0, 1, 1, 1, 4'hE);
      for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 4'h0);
      // down wrap
      for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 4'h3);
      step(0, 0, 1, 0, 4'h3);
      // load priority over count, tc still reported
      step(0, 1, 0, 1, 4'h5);
      step(0, 1, 1, 0, 4'h9);
      // hold then direction flip
      step(0, 1, 0, 0, 4'h7);
      for (int i = 0; i < 4; i++) step(0, 0, 0, logic'(i[0]), 4'hC);
      for (int i = 0; i < 4; i++) step(0, 0, 1, logic'(~i[0]), 4'h1);
      // reset mid-count
      step(0, 1, 0, 0, 4'h3);
      for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 4'h0);
      step(1, 0, 1, 1, 4'hB);
      for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 4'h0);
      // random traffic
      for (int i = 0; i < 400; i++) begin
         step(logic'($urandom_range(29, 0) == 0),
              logic'($urandom_range(7, 0) == 0),
              logic'($urandom_range(3, 0) != 0),
              logic'($urandom_range(1, 0)),
              W'($urandom_range(MOD - 1, 0)));
      end
      repeat (4) @(negedge clk);
      #1;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending expected 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
